// File: rtl/day1_instr_parser.sv
// Purpose: parse ASCII "L68\n"-style lines into (direction, magnitude) instructions.
// Latency: instruction_valid strobes 1 cycle after the terminating byte is accepted.
// Backpressure: byte_ready is high in every state except DONE; full-rate input never stalls.
module day1_instr_parser #(
  parameter int MAG_WIDTH   = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  input  logic                   byte_last,
  output logic                   byte_ready,
  output logic                   direction,
  output logic [MAG_WIDTH-1:0]   magnitude,
  output logic                   instruction_valid,
  output logic [COUNT_WIDTH-1:0] instruction_count,
  output logic                   parse_error,
  output logic                   overflow,
  output logic                   done
);

  typedef enum logic [2:0] {
    EXPECT_DIR,
    EXPECT_DIGIT,
    DIGITS,
    SKIP,
    DONE
  } state_t;

  localparam logic [MAG_WIDTH+3:0] MAG_MAX = {4'b0000, {MAG_WIDTH{1'b1}}};

  state_t                 state, state_nxt;
  logic                   pend_dir, pend_dir_nxt;
  logic [MAG_WIDTH-1:0]   acc, acc_nxt;
  logic                   emit, err_set, ovf_set;
  logic                   accept, is_digit, is_cr, is_lf, is_l, is_r;
  logic [3:0]             digit;
  logic [MAG_WIDTH+3:0]   acc_x10;

  assign byte_ready = (state != DONE);
  assign accept     = byte_valid & byte_ready;
  assign is_digit   = (byte_in >= 8'h30) && (byte_in <= 8'h39);
  assign is_cr      = (byte_in == 8'h0D);
  assign is_lf      = (byte_in == 8'h0A);
  assign is_l       = (byte_in == 8'h4C);
  assign is_r       = (byte_in == 8'h52);
  // ASCII '0'..'9' carry their value in the low nibble.
  assign digit      = byte_in[3:0];
  // acc*10 + d, widened by 4 bits so the saturation test sees the true result.
  assign acc_x10    = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                    + {{MAG_WIDTH{1'b0}}, digit};

  // Next-state, accumulator update and per-byte emit/error decisions.
  always_comb begin
    state_nxt    = state;
    pend_dir_nxt = pend_dir;
    acc_nxt      = acc;
    emit         = 1'b0;
    err_set      = 1'b0;
    ovf_set      = 1'b0;
    if (accept) begin
      case (state)
        EXPECT_DIR: begin
          if (is_l || is_r) begin
            pend_dir_nxt = is_r;
            acc_nxt      = '0;
            state_nxt    = EXPECT_DIGIT;
          end else if (!(is_cr || is_lf)) begin
            err_set   = 1'b1;
            state_nxt = SKIP;
          end
        end
        EXPECT_DIGIT: begin
          if (is_digit) begin
            acc_nxt   = MAG_WIDTH'(digit);
            state_nxt = DIGITS;
          end else if (is_lf) begin
            err_set   = 1'b1;
            state_nxt = EXPECT_DIR;
          end else if (!is_cr) begin
            err_set   = 1'b1;
            state_nxt = SKIP;
          end
        end
        DIGITS: begin
          if (is_digit) begin
            if (acc_x10 > MAG_MAX) begin
              acc_nxt = '1;
              ovf_set = 1'b1;
            end else begin
              acc_nxt = acc_x10[MAG_WIDTH-1:0];
            end
          end else if (is_lf) begin
            emit      = 1'b1;
            state_nxt = EXPECT_DIR;
          end else if (!is_cr) begin
            err_set   = 1'b1;
            state_nxt = SKIP;
          end
        end
        SKIP: begin
          if (is_lf) state_nxt = EXPECT_DIR;
        end
        default: ;
      endcase
      // The final byte closes any line still holding digits, then the parser parks.
      if (byte_last) begin
        if (state_nxt == DIGITS) emit = 1'b1;
        else if (state_nxt == EXPECT_DIGIT) err_set = 1'b1;
        state_nxt = DONE;
      end
    end
  end

  // FSM state, pending direction and digit accumulator.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= EXPECT_DIR;
      pend_dir <= 1'b0;
      acc      <= '0;
    end else begin
      state    <= state_nxt;
      pend_dir <= pend_dir_nxt;
      acc      <= acc_nxt;
    end
  end

  // Registered instruction outputs and sticky status flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      direction         <= 1'b0;
      magnitude         <= '0;
      instruction_valid <= 1'b0;
      instruction_count <= '0;
      parse_error       <= 1'b0;
      overflow          <= 1'b0;
      done              <= 1'b0;
    end else begin
      instruction_valid <= emit;
      if (emit) begin
        direction         <= pend_dir_nxt;
        magnitude         <= acc_nxt;
        instruction_count <= instruction_count + 1'b1;
      end
      parse_error <= parse_error | err_set;
      overflow    <= overflow | ovf_set;
      if (accept && byte_last) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_day1_instr_parser.sv
// Directed bench for day1_instr_parser: line-level reference model plus literal checks.
module tb_day1_instr_parser;

  logic        clock = 1'b0;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        direction;
  logic [15:0] magnitude;
  logic        instruction_valid;
  logic [31:0] instruction_count;
  logic        parse_error;
  logic        overflow;
  logic        done;

  day1_instr_parser #(.MAG_WIDTH(16), .COUNT_WIDTH(32)) dut (
    .clock(clock), .clear(clear), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .direction(direction),
    .magnitude(magnitude), .instruction_valid(instruction_valid),
    .instruction_count(instruction_count), .parse_error(parse_error),
    .overflow(overflow), .done(done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [16:0] strobes[$];

  // Reference model: collects each line (carriage returns dropped) and judges it as text.
  logic [7:0]  m_line[$];
  logic        m_dir = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_ovf = 1'b0, m_done = 1'b0;
  logic [15:0] m_mag = '0;
  logic [31:0] m_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Walk the line so far: direction letter then decimal digits, saturating at 65535.
  task automatic scan_line(output bit err, output bit ovf, output int unsigned val);
    err = 0; ovf = 0; val = 0;
    if (m_line.size() == 0) return;
    if (m_line[0] != 8'h4C && m_line[0] != 8'h52) begin err = 1; return; end
    for (int i = 1; i < m_line.size(); i++) begin
      if (m_line[i] < 8'h30 || m_line[i] > 8'h39) begin err = 1; return; end
      val = val * 10 + 32'(m_line[i] - 8'h30);
      if (val > 65535) begin val = 65535; ovf = 1; end
    end
  endtask

  task automatic model_step(input logic [7:0] b, input logic last);
    bit e, o;
    int unsigned v;
    if (b != 8'h0D && b != 8'h0A) m_line.push_back(b);
    scan_line(e, o, v);
    if (e) m_err = 1;
    if (o) m_ovf = 1;
    if (b == 8'h0A || last) begin
      if (m_line.size() > 0 && !e) begin
        if (m_line.size() == 1) m_err = 1;
        else begin
          m_valid = 1;
          m_dir   = (m_line[0] == 8'h52);
          m_mag   = v[15:0];
          m_count = m_count + 1;
        end
      end
      m_line.delete();
      if (last) m_done = 1;
    end
  endtask

  always @(posedge clock) begin
    m_valid = 0;
    if (clear) begin
      m_line.delete();
      m_dir = 0; m_mag = '0; m_count = '0; m_err = 0; m_ovf = 0; m_done = 0;
    end else if (byte_valid && !m_done) begin
      model_step(byte_in, byte_last);
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("byte_ready", 32'(byte_ready), 32'(!m_done));
      check("instruction_valid", 32'(instruction_valid), 32'(m_valid));
      check("direction", 32'(direction), 32'(m_dir));
      check("magnitude", 32'(magnitude), 32'(m_mag));
      check("instruction_count", instruction_count, m_count);
      check("parse_error", 32'(parse_error), 32'(m_err));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("done", 32'(done), 32'(m_done));
      if (instruction_valid === 1'b1) strobes.push_back({direction, magnitude});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  // Offer each character; last marks the final one; toggle inserts an idle cycle after each.
  task automatic send(input string s, input bit last, input bit toggle);
    for (int i = 0; i < s.len(); i++) begin
      byte_in    = s.getc(i);
      byte_valid = 1'b1;
      byte_last  = last && (i == s.len() - 1);
      @(posedge clock); #1;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      if (toggle) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic start_test();
    do_clear();
    strobes.delete();
  endtask

  initial begin
    clear = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
    @(posedge clock); #1;
    clear = 1'b0;
    chk_en = 1'b1;
    // Reset state
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_valid", 32'(instruction_valid), 32'd0);
    check("rst_count", instruction_count, 32'd0);
    check("rst_mag", 32'(magnitude), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // 1: two lines at full rate, strobe one cycle after each '\n'
    start_test();
    send("L68\n", 0, 0);
    check("t1_lat_a", 32'(instruction_valid), 32'd1);
    check("t1_mag_a", 32'(magnitude), 32'd68);
    send("R5\n", 0, 0);
    check("t1_lat_b", 32'(instruction_valid), 32'd1);
    idle(2);
    check("t1_nstrobes", 32'(strobes.size()), 32'd2);
    if (strobes.size() == 2) begin
      check("t1_s0", 32'(strobes[0]), {15'd0, 1'b0, 16'd68});
      check("t1_s1", 32'(strobes[1]), {15'd0, 1'b1, 16'd5});
    end
    check("t1_count", instruction_count, 32'd2);
    check("t1_model_count", m_count, 32'd2);

    // 2: missing final newline, last on a digit
    start_test();
    send("R1000", 1, 0);
    check("t2_valid", 32'(instruction_valid), 32'd1);
    check("t2_done", 32'(done), 32'd1);
    check("t2_mag", 32'(magnitude), 32'd1000);
    check("t2_dir", 32'(direction), 32'd1);
    idle(1);
    check("t2_ready_low", 32'(byte_ready), 32'd0);
    send("L5\n", 0, 0);
    idle(2);
    check("t2_count_held", instruction_count, 32'd1);
    check("t2_mag_held", 32'(magnitude), 32'd1000);

    // 3: saturating magnitude
    start_test();
    send("R99999\n", 0, 0);
    idle(2);
    check("t3_nstrobes", 32'(strobes.size()), 32'd1);
    check("t3_mag", 32'(magnitude), 32'd65535);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_err", 32'(parse_error), 32'd0);

    // 4: malformed lines are dropped
    start_test();
    send("X12\nL\nL3\n", 0, 0);
    idle(2);
    check("t4_err", 32'(parse_error), 32'd1);
    check("t4_nstrobes", 32'(strobes.size()), 32'd1);
    if (strobes.size() == 1) check("t4_s0", 32'(strobes[0]), {15'd0, 1'b0, 16'd3});
    check("t4_count", instruction_count, 32'd1);

    // 5: blank lines and CR with gapped valid
    start_test();
    send("\015\n\nR7\015\n", 0, 1);
    idle(2);
    check("t5_nstrobes", 32'(strobes.size()), 32'd1);
    if (strobes.size() == 1) check("t5_s0", 32'(strobes[0]), {15'd0, 1'b1, 16'd7});
    check("t5_err", 32'(parse_error), 32'd0);

    // 6: clear mid-line discards the partial line
    start_test();
    send("R4", 0, 0);
    do_clear();
    send("L2\n", 0, 0);
    idle(2);
    check("t6_nstrobes", 32'(strobes.size()), 32'd1);
    if (strobes.size() == 1) check("t6_s0", 32'(strobes[0]), {15'd0, 1'b0, 16'd2});
    check("t6_count", instruction_count, 32'd1);
    check("t6_flags", {29'd0, parse_error, overflow, done}, 32'd0);

    // 7: last byte leaves a direction with no digits
    start_test();
    send("L", 1, 0);
    idle(1);
    check("t7_err", 32'(parse_error), 32'd1);
    check("t7_done", 32'(done), 32'd1);
    check("t7_count", instruction_count, 32'd0);

    // 8: last flag on a terminating newline, three back-to-back lines
    start_test();
    send("R3\nL4\nR12\n", 1, 0);
    check("t8_done_with_strobe", {30'd0, done, instruction_valid}, 32'd3);
    idle(2);
    check("t8_count", instruction_count, 32'd3);
    if (strobes.size() == 3) check("t8_s2", 32'(strobes[2]), {15'd0, 1'b1, 16'd12});
    else check("t8_nstrobes", 32'(strobes.size()), 32'd3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
